// File: rtl/uart_rx_bit_counter.sv
// 8N1 receive monitor: counts bit slots sampled per frame (1=start, 2..9=data, 10=stop ok, F=framing error).
// Build with RX_SYNC_EN for a 2-flop input synchronizer; otherwise a single input register is used.
module uart_rx_bit_counter #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic [3:0] receive_counter
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic rx_s;

`ifdef RX_SYNC_EN
  localparam int VLD_W = 3;
  logic rx_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
    end
  end
`else
  localparam int VLD_W = 2;

  always_ff @(posedge clk) begin
    if (rst) rx_s <= 1'b1;
    else     rx_s <= rx_data;
  end
`endif

  // line_vld marks which pipeline stages hold post-reset samples, so a line
  // held low through reset release never looks like a falling edge.
  logic             rx_prev;
  logic [VLD_W-1:0] line_vld;
  logic             fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev  <= 1'b1;
      line_vld <= '0;
    end else begin
      rx_prev  <= rx_s;
      line_vld <= {line_vld[VLD_W-2:0], 1'b1};
    end
  end

  assign fall = line_vld[VLD_W-1] & rx_prev & ~rx_s;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [3:0]        cnt_nxt;
  logic [7:0]        data_sr, sr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      baud_cnt        <= '0;
      receive_counter <= 4'd0;
      data_sr         <= 8'd0;
    end else begin
      state           <= state_nxt;
      baud_cnt        <= baud_nxt;
      receive_counter <= cnt_nxt;
      data_sr         <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    cnt_nxt   = receive_counter;
    sr_nxt    = data_sr;
    case (state)
      S_IDLE: begin
        if (fall) begin
          cnt_nxt   = 4'd0;
          baud_nxt  = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nxt = '0;
          if (!rx_s) begin
            cnt_nxt   = 4'd1;
            state_nxt = S_DATA;
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nxt = '0;
          sr_nxt   = {rx_s, data_sr[7:1]};
          cnt_nxt  = receive_counter + 4'd1;
          if (receive_counter == 4'd8) state_nxt = S_STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_nxt = '0;
          if (rx_s) begin
            cnt_nxt   = 4'd10;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt   = 4'hF;
            state_nxt = S_BREAK;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_bit_counter.sv
// Directed bench for uart_rx_bit_counter, run with a short bit period (20 clocks) to keep frames brief.
module tb_uart_rx_bit_counter;

  localparam int CPB  = 20;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data = 1'b1;
  logic [3:0] receive_counter;

  int total = 0;
  int bad   = 0;

  uart_rx_bit_counter #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .receive_counter(receive_counter)
  );

  always #5 clk = ~clk;

  // Starts #1 after a posedge and ends #1 after the posedge one bit period later.
  // pre: counter just before the mid-bit sample lands, post: just after.
  task automatic slot(input logic v, output logic [3:0] pre, output logic [3:0] post);
    rx_data = v;
    repeat (HALF + 1) @(posedge clk);
    #1 pre = receive_counter;
    @(posedge clk);
    #1 post = receive_counter;
    repeat (CPB - HALF - 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL reset_value: got %0h expected 0", receive_counter);
    end
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: got %0h expected 0", receive_counter);
    end
  endtask

  task automatic test_valid_frame();
    logic [9:0] bits;
    logic [3:0] pre, post;
    bits = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      slot(bits[k], pre, post);
      total++;
      if (pre !== 4'(k)) begin
        bad++;
        $display("FAIL valid_pre_%0d: got %0h expected %0h", k, pre, 4'(k));
      end
      total++;
      if (post !== 4'(k + 1)) begin
        bad++;
        $display("FAIL valid_post_%0d: got %0h expected %0h", k, post, 4'(k + 1));
      end
    end
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd10) begin
      bad++;
      $display("FAIL valid_hold: got %0h expected a", receive_counter);
    end
  endtask

  task automatic test_false_start();
    logic [9:0] bits;
    logic [3:0] pre, post;
    rx_data = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL false_start_clear: got %0h expected 0", receive_counter);
    end
    rx_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL false_start_mid: got %0h expected 0", receive_counter);
    end
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL false_start_idle: got %0h expected 0", receive_counter);
    end
    bits = {1'b1, 8'h0F, 1'b0};
    for (int k = 0; k < 10; k++) begin
      slot(bits[k], pre, post);
      total++;
      if (post !== 4'(k + 1)) begin
        bad++;
        $display("FAIL after_false_post_%0d: got %0h expected %0h", k, post, 4'(k + 1));
      end
    end
  endtask

  task automatic test_framing_error();
    logic [9:0] bits;
    logic [3:0] pre, post, exp_post;
    bits = {1'b0, 8'hC3, 1'b0};
    for (int k = 0; k < 10; k++) begin
      slot(bits[k], pre, post);
      exp_post = (k == 9) ? 4'hF : 4'(k + 1);
      total++;
      if (pre !== 4'(k)) begin
        bad++;
        $display("FAIL ferr_pre_%0d: got %0h expected %0h", k, pre, 4'(k));
      end
      total++;
      if (post !== exp_post) begin
        bad++;
        $display("FAIL ferr_post_%0d: got %0h expected %0h", k, post, exp_post);
      end
    end
    repeat (100) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'hF) begin
      bad++;
      $display("FAIL ferr_hold_low: got %0h expected f", receive_counter);
    end
    rx_data = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'hF) begin
      bad++;
      $display("FAIL ferr_hold_high: got %0h expected f", receive_counter);
    end
    bits = {1'b1, 8'h81, 1'b0};
    for (int k = 0; k < 10; k++) begin
      slot(bits[k], pre, post);
      total++;
      if (pre !== 4'(k) || post !== 4'(k + 1)) begin
        bad++;
        $display("FAIL ferr_recover_%0d: got %0h/%0h expected %0h/%0h",
                 k, pre, post, 4'(k), 4'(k + 1));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    logic [3:0] pre, post;
    bits = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 5; k++) begin
      slot(bits[k], pre, post);
      total++;
      if (post !== 4'(k + 1)) begin
        bad++;
        $display("FAIL midrst_post_%0d: got %0h expected %0h", k, post, 4'(k + 1));
      end
    end
    rx_data = bits[5];
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL midrst_abort: got %0h expected 0", receive_counter);
    end
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL midrst_idle: got %0h expected 0", receive_counter);
    end
    // line held low across reset release must not start a frame
    rx_data = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (receive_counter !== 4'd0) begin
      bad++;
      $display("FAIL held_low_no_start: got %0h expected 0", receive_counter);
    end
    rx_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bits = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 10; k++) begin
      slot(bits[k], pre, post);
      total++;
      if (pre !== 4'(k) || post !== 4'(k + 1)) begin
        bad++;
        $display("FAIL midrst_recover_%0d: got %0h/%0h expected %0h/%0h",
                 k, pre, post, 4'(k), 4'(k + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits [2];
    logic [3:0] pre, post;
    bits[0] = {1'b1, 8'hA3, 1'b0};
    bits[1] = {1'b1, 8'h00, 1'b0};
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10; k++) begin
        slot(bits[f][k], pre, post);
        total++;
        if (pre !== 4'(k)) begin
          bad++;
          $display("FAIL b2b_f%0d_pre_%0d: got %0h expected %0h", f, k, pre, 4'(k));
        end
        total++;
        if (post !== 4'(k + 1)) begin
          bad++;
          $display("FAIL b2b_f%0d_post_%0d: got %0h expected %0h", f, k, post, 4'(k + 1));
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_valid_frame();
    test_false_start();
    test_framing_error();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
